// File: rtl/inst_queue_pkg.sv
// Shared pipeline types: the decoded-instruction record passed between stages
// and the queue depth used by the decode-to-dispatch instruction queue.
package Public_Info;

  typedef struct packed {
    logic        o_valid;
    logic [31:0] PC;
    logic [31:0] inst;
  } PC_set;

  localparam int unsigned IQ_DEPTH = 8;

endpackage

// File: rtl/inst_queue.sv
// Decoded-instruction queue between decode and dual-issue dispatch.
// Takes up to two entries per cycle in program order and exposes the two oldest.
module inst_queue
  import Public_Info::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           flush,
  input  PC_set          i_set1,
  input  PC_set          i_set2,
  output logic           o_ready,
  input  logic [1:0]     i_usingNUM,
  output PC_set          o_set1,
  output PC_set          o_set2,
  output logic [PTR_W:0] o_count
);

  localparam logic [PTR_W:0] ReadyMax = (PTR_W+1)'(DEPTH - 2);

  PC_set            mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_p1, wr_ptr_p1;
  logic [PTR_W:0]   count_q;
  logic [1:0]       enq, deq;
  logic             wr0_en, wr1_en;
  PC_set            wr0_data;

  assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);
  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

  // Registered count only, so the dispatch path never reaches decode backpressure.
  assign o_ready = (count_q <= ReadyMax);
  assign o_count = count_q;

  always_comb begin
    enq      = '0;
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_data = i_set1;
    if (o_ready && !flush) begin
      unique case ({i_set1.o_valid, i_set2.o_valid})
        2'b11: begin
          wr0_en = 1'b1;
          wr1_en = 1'b1;
          enq    = 2'd2;
        end
        2'b10: begin
          wr0_en = 1'b1;
          enq    = 2'd1;
        end
        2'b01: begin
          // A lone younger entry is compacted into the next free slot.
          wr0_en   = 1'b1;
          wr0_data = i_set2;
          enq      = 2'd1;
        end
        default: enq = '0;
      endcase
    end
    if ((PTR_W+1)'(i_usingNUM) > count_q) begin
      deq = 2'(count_q);
    end else begin
      deq = i_usingNUM;
    end
  end

  always_ff @(posedge clk) begin
    if (wr0_en) mem_q[wr_ptr_q]  <= wr0_data;
    if (wr1_en) mem_q[wr_ptr_p1] <= i_set2;
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PTR_W'(deq);
      wr_ptr_q <= wr_ptr_q + PTR_W'(enq);
      count_q  <= count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
    end
  end

  always_comb begin
    o_set1         = mem_q[rd_ptr_q];
    o_set1.o_valid = (count_q != '0);
    o_set2         = mem_q[rd_ptr_p1];
    o_set2.o_valid = (count_q >= (PTR_W+1)'(2));
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rstn && !flush) begin
      assert ((PTR_W+1)'(i_usingNUM) <= count_q)
      else $warning("inst_queue: i_usingNUM=%0d above occupancy %0d, clamped",
                    i_usingNUM, count_q);
    end
  end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed and randomized bench for inst_queue against a queue-based program-order model.
module tb_inst_queue;
  import Public_Info::*;

  localparam int unsigned DEPTH = IQ_DEPTH;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic           clk   = 1'b0;
  logic           rstn  = 1'b0;
  logic           flush = 1'b0;
  PC_set          set1, set2, head1, head2;
  logic           ready;
  logic [1:0]     using_num;
  logic [PTR_W:0] count;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] model[$];
  logic [31:0] next_pc = 32'h1c00_0000;

  always #5 clk = ~clk;

  inst_queue #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .i_set1    (set1),
    .i_set2    (set2),
    .o_ready   (ready),
    .i_usingNUM(using_num),
    .o_set1    (head1),
    .o_set2    (head2),
    .o_count   (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int n = model.size();
    chk("count", 64'(count), 64'(n));
    chk("ready", 64'(ready), 64'(n <= int'(DEPTH) - 2));
    chk("valid1", 64'(head1.o_valid), 64'(n >= 1));
    chk("valid2", 64'(head2.o_valid), 64'(n >= 2));
    if (n >= 1) begin
      chk("pc1", 64'(head1.PC), 64'(model[0][63:32]));
      chk("inst1", 64'(head1.inst), 64'(model[0][31:0]));
    end
    if (n >= 2) begin
      chk("pc2", 64'(head2.PC), 64'(model[1][63:32]));
      chk("inst2", 64'(head2.inst), 64'(model[1][31:0]));
    end
  endtask

  task automatic idle_inputs();
    set1      = '0;
    set2      = '0;
    using_num = 2'd0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    model.delete();
    #1;
    check_outputs();
    rstn = 1'b1;
  endtask

  // One clock: drive a push/issue/flush, then advance the model by the queue rules.
  task automatic cycle(input bit v1, input bit v2, input int use_n, input bit fl);
    int n   = model.size();
    bit rdy = (n <= int'(DEPTH) - 2);
    int take;
    set1.o_valid = v1;
    set1.PC      = v1 ? next_pc : 32'hdead_beef;
    set1.inst    = $urandom;
    set2.o_valid = v2;
    set2.PC      = v1 ? next_pc + 32'd4 : next_pc;
    set2.inst    = $urandom;
    using_num    = 2'(use_n);
    flush        = fl;
    @(posedge clk);
    if (fl) begin
      model.delete();
    end else begin
      take = (use_n < n) ? use_n : n;
      repeat (take) void'(model.pop_front());
      if (rdy) begin
        if (v1) model.push_back({set1.PC, set1.inst});
        if (v2) model.push_back({set2.PC, set2.inst});
        next_pc += 32'd4 * (32'(v1) + 32'(v2));
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // Fill with pairs and no issue.
    repeat (3) cycle(1, 1, 0, 0);
    chk("fill_count", 64'(count), 64'd6);
    chk("fill_pc1", 64'(head1.PC), 64'h1c00_0000);
    chk("fill_pc2", 64'(head2.PC), 64'h1c00_0004);
    cycle(1, 0, 0, 0);
    chk("full7_ready", 64'(ready), 64'd0);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 1, 0, 0);
    chk("full8_count", 64'(count), 64'd8);
    cycle(1, 1, 2, 0);
    cycle(0, 0, 1, 0);

    // Single issue at steady occupancy, wrapping the pointers.
    repeat (10) cycle(1, 0, 1, 0);
    chk("odd_count", 64'(count), 64'd5);

    // Two in, two out at occupancy 6.
    cycle(1, 0, 0, 0);
    repeat (4) cycle(1, 1, 2, 0);
    chk("simul_count", 64'(count), 64'd6);

    // Flush beats a same-cycle push and issue.
    cycle(0, 0, 1, 0);
    cycle(1, 1, 2, 1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_ready", 64'(ready), 64'd1);

    // Lone younger entry lands at the head.
    next_pc = 32'h1c00_0040;
    cycle(0, 1, 0, 0);
    chk("compact_pc", 64'(head1.PC), 64'h1c00_0040);
    chk("compact_v2", 64'(head2.o_valid), 64'd0);

    // Over-issue clamps to occupancy.
    cycle(0, 0, 2, 0);
    chk("clamp_count", 64'(count), 64'd0);

    for (int i = 0; i < 400; i++) begin
      int n = model.size();
      int hi = (n < 2) ? n : 2;
      if (i == 200) begin
        do_reset();
        n  = 0;
        hi = 0;
      end
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, hi)), ($urandom_range(0, 31) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
